// File: rtl/add_tree_acc.sv
// Pipelined FP16 reduction tree with valid/ready flow control and an optional
// multi-beat accumulate stage for dot products longer than one beat.
module add_tree_acc #(
  parameter int N_IN  = 128,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [15:0]        in_data_i [N_IN-1:0],
  input  logic               in_mode_i,
  input  logic               in_last_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [15:0]        out_data_o,
  output logic [CNT_W-1:0]   out_beats_o
);

  localparam int LVL = $clog2(N_IN);

  // FP16 add, round-to-nearest-even; NaN results are the canonical quiet NaN.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, r;
    logic [5:0]  ex, ey, e, d;
    logic [10:0] mx, my;
    logic [13:0] gx, gy, mask;
    logic [14:0] s;
    logic [11:0] m;
    logic        sx, sub, st, rnd;
    if (a[14:0] >= b[14:0]) begin
      x = a;
      y = b;
    end else begin
      x = b;
      y = a;
    end
    sx   = x[15];
    sub  = x[15] ^ y[15];
    r    = 16'h0000;
    ex   = 6'd0;
    ey   = 6'd0;
    e    = 6'd0;
    d    = 6'd0;
    mx   = 11'd0;
    my   = 11'd0;
    gx   = 14'd0;
    gy   = 14'd0;
    mask = 14'd0;
    s    = 15'd0;
    m    = 12'd0;
    st   = 1'b0;
    rnd  = 1'b0;
    if (x[14:10] == 5'h1f) begin
      if (x[9:0] != 10'd0 || (y[14:10] == 5'h1f && sub)) r = 16'h7E00;
      else r = x;
    end else begin
      ex = (x[14:10] == 5'd0) ? 6'd1 : {1'b0, x[14:10]};
      ey = (y[14:10] == 5'd0) ? 6'd1 : {1'b0, y[14:10]};
      mx = {x[14:10] != 5'd0, x[9:0]};
      my = {y[14:10] != 5'd0, y[9:0]};
      d  = ex - ey;
      gx = {mx, 3'b000};
      gy = {my, 3'b000};
      if (d > 6'd13) begin
        st = |gy;
        gy = 14'd0;
      end else begin
        mask = (14'd1 << d) - 14'd1;
        st   = |(gy & mask);
        gy   = gy >> d;
      end
      gy[0] = gy[0] | st;
      s = sub ? ({1'b0, gx} - {1'b0, gy}) : ({1'b0, gx} + {1'b0, gy});
      e = ex;
      if (s == 15'd0) begin
        r = sub ? 16'h0000 : {sx, 15'h0000};
      end else begin
        if (s[14]) begin
          s = {1'b0, s[14:2], s[1] | s[0]};
          e = e + 6'd1;
        end
        for (int i = 0; i < 13; i++) begin
          if (!s[13] && e > 6'd1) begin
            s = {s[13:0], 1'b0};
            e = e - 6'd1;
          end
        end
        rnd = s[2] & (s[1] | s[0] | s[3]);
        m   = {1'b0, s[13:3]} + {11'd0, rnd};
        if (m[11]) begin
          m = {1'b0, m[11:1]};
          e = e + 6'd1;
        end
        // A subnormal that rounds up into bit 10 picks up exponent 1 naturally.
        if (e >= 6'd31) r = {sx, 5'h1f, 10'h000};
        else r = {sx, m[10] ? e[4:0] : 5'd0, m[9:0]};
      end
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  logic             en, accept;
  logic             first_in, last_in;
  logic             group_open_q;
  logic [15:0]      node_q [2:2*N_IN-1];
  logic [15:0]      node_d [2:2*N_IN-1];
  logic [LVL-1:0]   vld_q, mode_q, first_q, last_q;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, beats_res;
  logic [15:0]      tree_sum, acc_base, sum;
  logic             v_l, mode_l, first_l, last_l, produce;
  logic             out_valid_q;
  logic [15:0]      out_data_q;
  logic [CNT_W-1:0] out_beats_q;

  assign en         = !out_valid_q | out_ready_i;
  assign in_ready_o = en;
  assign accept     = in_valid_i & en;
  assign first_in   = in_mode_i ? !group_open_q : 1'b1;
  assign last_in    = in_mode_i ? in_last_i : 1'b1;

  // Heap layout: stage 0 holds lanes at nodes N_IN.., node i sums nodes 2i and 2i+1.
  always_comb begin
    for (int i = 2; i < N_IN; i++) node_d[i] = fp16_add(node_q[2*i], node_q[2*i+1]);
    for (int j = 0; j < N_IN; j++) node_d[N_IN+j] = in_data_i[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 2; i < 2*N_IN; i++) node_q[i] <= 16'h0000;
    end else if (en) begin
      for (int i = 2; i < N_IN; i++) node_q[i] <= node_d[i];
      if (accept) begin
        for (int j = N_IN; j < 2*N_IN; j++) node_q[j] <= node_d[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q        <= '0;
      mode_q       <= '0;
      first_q      <= '0;
      last_q       <= '0;
      group_open_q <= 1'b0;
    end else if (en) begin
      for (int i = LVL-1; i > 0; i--) begin
        vld_q[i]   <= vld_q[i-1];
        mode_q[i]  <= mode_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
      end
      vld_q[0]   <= accept;
      mode_q[0]  <= in_mode_i;
      first_q[0] <= first_in;
      last_q[0]  <= last_in;
      if (accept && in_mode_i) group_open_q <= !in_last_i;
    end
  end

  // Accumulate stage: last tree adder feeds the accumulate adder combinationally.
  assign v_l      = vld_q[LVL-1];
  assign mode_l   = mode_q[LVL-1];
  assign first_l  = first_q[LVL-1];
  assign last_l   = last_q[LVL-1];
  assign tree_sum = fp16_add(node_q[2], node_q[3]);

  always_comb begin
    acc_base  = first_l ? 16'h0000 : acc_q;
    sum       = fp16_add(acc_base, tree_sum);
    cnt_inc   = first_l ? CNT_W'(1) : sat_inc(cnt_q);
    produce   = v_l & (!mode_l | last_l);
    beats_res = mode_l ? cnt_inc : CNT_W'(1);
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    if (v_l && mode_l) begin
      if (last_l) begin
        acc_d = 16'h0000;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= 16'h0000;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_beats_q <= '0;
    end else if (en) begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= produce;
      if (produce) begin
        out_data_q  <= sum;
        out_beats_q <= beats_res;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_beats_o = out_beats_q;

endmodule
